// File: rtl/serial_xor_pkg.sv
// Shared definitions for the serial XOR arbiter: FSM state encoding and
// the default operand width.
package serial_xor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_xor_arb_xor_cell.sv
// Single-bit XOR cell; the only arithmetic element in the serial datapath.
module xor_cell (
  input  logic A,
  input  logic B,
  output logic C
);

  assign C = A ^ B;

endmodule

// File: rtl/serial_xor_arb.sv
// Two-requester round-robin arbiter feeding a bit-serial XOR engine that
// computes y = a ^ b one bit per cycle through a shared 1-bit cell.
module serial_xor_arb
  import serial_xor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] y,
  output logic             parity
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
  logic             cur_owner, last_owner;
  logic             any_req, win1, last_bit, xor_bit;

  // Result bits enter from the MSB so that after WIDTH shifts bit 0 lands at 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r,
                                                input logic b);
    logic [WIDTH-1:0] t;
    t = r >> 1;
    t[WIDTH-1] = b;
    return t;
  endfunction

  assign any_req  = req0 | req1;
  assign win1     = req1 & (~req0 | ~last_owner);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign res_nxt  = shift_in(res_sr, xor_bit);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  xor_cell u_xor_cell (
    .A (a_sr[0]),
    .B (b_sr[0]),
    .C (xor_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      cnt        <= '0;
      y          <= '0;
      parity     <= 1'b0;
      owner      <= 1'b0;
      cur_owner  <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt0      <= ~win1;
            gnt1      <= win1;
            cur_owner <= win1;
            cnt       <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            y      <= res_nxt;
            parity <= ^res_nxt;
            owner  <= cur_owner;
          end
        end
        DONE:    last_owner <= cur_owner;
        default: ;
      endcase
    end
  end

  // Serial datapath; fully overwritten on capture, so no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      a_sr <= win1 ? a1 : a0;
      b_sr <= win1 ? b1 : b0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt;
    end
  end

endmodule

// File: tb/tb_serial_xor_arb.sv
// Directed bench for serial_xor_arb at WIDTH=8; inputs driven and outputs
// sampled on the falling edge.
module tb_serial_xor_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, owner, parity;
  logic [W-1:0] y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_xor_arb #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .a0     (a0),
    .b0     (b0),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .busy   (busy),
    .done   (done),
    .owner  (owner),
    .y      (y),
    .parity (parity)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    step(); step();
    total++;
    if ({gnt0, gnt1, busy, done} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {gnt0, gnt1, busy, done});
    end
    total++;
    if ({owner, parity, y} !== '0) begin
      bad++; $display("FAIL reset_result got=%h want=0", {owner, parity, y});
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (gnt0 !== (k == 1) || gnt1 !== 1'b0) begin
        bad++; $display("FAIL single_gnt k=%0d got=%b%b want=%b0", k, gnt0, gnt1, (k == 1));
      end
      total++;
      if (done !== (k == 9)) begin
        bad++; $display("FAIL single_done k=%0d got=%b want=%b", k, done, (k == 9));
      end
      total++;
      if (busy !== (k <= 9)) begin
        bad++; $display("FAIL single_busy k=%0d got=%b want=%b", k, busy, (k <= 9));
      end
      if (k == 9 || k == 10) begin
        total++;
        if (y !== 8'hAA || parity !== 1'b0 || owner !== 1'b0) begin
          bad++; $display("FAIL single_result k=%0d got=%h/%b/%b want=aa/0/0", k, y, parity, owner);
        end
      end
      if (k == 1) begin
        req0 = 1'b0; a0 = 8'h00; b0 = 8'hFF;
      end
    end
  endtask

  task automatic test_both();
    int g0 = -1, g1 = -1, dn = 0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'hFF; b0 = 8'h00; a1 = 8'h12; b1 = 8'h34;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (gnt0 && gnt1) begin
        bad++; $display("FAIL both_overlap k=%0d got=11 want=not both", k);
      end
      if (gnt0 && g0 < 0) g0 = k;
      if (gnt1 && g1 < 0) g1 = k;
      if (done) begin
        dn++;
        if (dn == 1) begin
          total++;
          if (k != 9 || y !== 8'hFF || owner !== 1'b0 || parity !== 1'b0) begin
            bad++; $display("FAIL both_first k=%0d got=%h/%b/%b want=9:ff/0/0", k, y, owner, parity);
          end
        end else if (dn == 2) begin
          total++;
          if (k != 19 || y !== 8'h26 || owner !== 1'b1 || parity !== 1'b1) begin
            bad++; $display("FAIL both_second k=%0d got=%h/%b/%b want=19:26/1/1", k, y, owner, parity);
          end
        end
      end
    end
    total++;
    if (g0 != 1 || g1 != 11) begin
      bad++; $display("FAIL both_gnt_times got=%0d,%0d want=1,11", g0, g1);
    end
    total++;
    if (dn != 2) begin
      bad++; $display("FAIL both_done_count got=%0d want=2", dn);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_rotation();
    int own[4];
    int n = 0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h01; b0 = 8'h02; a1 = 8'h04; b1 = 8'h08;
    for (int k = 1; k <= 60 && n < 4; k++) begin
      step();
      total++;
      if (gnt0 && gnt1) begin
        bad++; $display("FAIL rot_overlap k=%0d got=11 want=not both", k);
      end
      if (done) begin
        own[n] = int'(owner);
        n++;
      end
    end
    total++;
    if (n != 4) begin
      bad++; $display("FAIL rot_timeout got=%0d dones want=4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (own[i] != (i % 2)) begin
          bad++; $display("FAIL rot_owner i=%0d got=%0d want=%0d", i, own[i], i % 2);
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1'b1; a0 = 8'h3C; b0 = 8'hC3;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) req0 = 1'b0;
    end
    req1 = 1'b1; a1 = 8'h01; b1 = 8'h00;
    step();
    total++;
    if (gnt1 !== 1'b1) begin
      bad++; $display("FAIL mid_gnt1 got=%b want=1", gnt1);
    end
    req1 = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_abort got=%b%b want=00", busy, done);
    end
    total++;
    if (y !== 8'h00 || owner !== 1'b0) begin
      bad++; $display("FAIL mid_clear got=%h/%b want=00/0", y, owner);
    end
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      total++;
      if (done !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        bad++; $display("FAIL mid_quiet k=%0d got=%b%b%b want=000", k, done, gnt0, gnt1);
      end
    end
    req0 = 1'b1; req1 = 1'b1;
    step();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++; $display("FAIL mid_contest got=%b%b want=10", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_pending();
    do_reset();
    req0 = 1'b1; a0 = 8'hF0; b0 = 8'h0F;
    a1 = 8'h12; b1 = 8'h34;
    for (int k = 1; k <= 21; k++) begin
      step();
      total++;
      if (gnt0 !== (k == 1) || gnt1 !== (k == 11)) begin
        bad++; $display("FAIL pend_gnt k=%0d got=%b%b want=%b%b", k, gnt0, gnt1, (k == 1), (k == 11));
      end
      total++;
      if (done !== (k == 9 || k == 19)) begin
        bad++; $display("FAIL pend_done k=%0d got=%b want=%b", k, done, (k == 9 || k == 19));
      end
      if (k == 10) begin
        total++;
        if (busy !== 1'b0) begin
          bad++; $display("FAIL pend_idle got=%b want=0", busy);
        end
      end
      if (k == 19) begin
        total++;
        if (y !== 8'h26 || owner !== 1'b1 || parity !== 1'b1) begin
          bad++; $display("FAIL pend_result got=%h/%b/%b want=26/1/1", y, owner, parity);
        end
      end
      if (k == 1) req0 = 1'b0;
      if (k == 3) req1 = 1'b1;
      if (k == 11) req1 = 1'b0;
    end
  endtask

  task automatic test_zero();
    req0 = 1'b1; a0 = 8'h5A; b0 = 8'h5A;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 1) req0 = 1'b0;
      if (k == 9) begin
        total++;
        if (done !== 1'b1 || y !== 8'h00 || parity !== 1'b0 || owner !== 1'b0) begin
          bad++; $display("FAIL zero_result got=%b/%h/%b/%b want=1/00/0/0", done, y, parity, owner);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_single();
    test_both();
    test_rotation();
    test_reset_mid();
    test_pending();
    test_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
